// File: rtl/long_op_scoreboard.sv
// Pending-register scoreboard for long-latency ops that complete outside the normal writeback.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle completion clear hazards immediately.
module long_op_scoreboard #(
   parameter int MAX_INFLIGHT = 2,
   localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          IssueD,
   input  logic [4:0]    RdD,
   input  logic [4:0]    Rs1D,
   input  logic [4:0]    Rs2D,
   input  logic          UseRs1D,
   input  logic          UseRs2D,
   input  logic          FlushD,
   input  logic          DoneW,
   input  logic [4:0]    DoneRd,
   output logic          StallF,
   output logic          StallD,
   output logic [31:0]   Pending,
   output logic [CW-1:0] InFlight,
   output logic          Full,
   output logic          Err
);

   logic [31:0]   pendingReg;
   logic [31:0]   pendingNext;
   logic [CW-1:0] inFlightReg;
   logic [CW-1:0] inFlightNext;
   logic          errReg;

   logic clr1, clr2, clrd;
   logic hit1, hit2, waw, cap, stall, accept, isFull;

`ifdef SCOREBOARD_BYPASS_EN
   assign clr1 = DoneW & (DoneRd == Rs1D);
   assign clr2 = DoneW & (DoneRd == Rs2D);
   assign clrd = DoneW & (DoneRd == RdD);
`else
   assign clr1 = 1'b0;
   assign clr2 = 1'b0;
   assign clrd = 1'b0;
`endif

   assign isFull = (inFlightReg == CW'(MAX_INFLIGHT));

   assign hit1   = UseRs1D & (Rs1D != 5'd0) & pendingReg[Rs1D] & ~clr1;
   assign hit2   = UseRs2D & (Rs2D != 5'd0) & pendingReg[Rs2D] & ~clr2;
   assign waw    = IssueD & (RdD != 5'd0) & pendingReg[RdD] & ~clrd;
   // A completion in the same cycle frees the slot the new issue needs.
   assign cap    = IssueD & isFull & ~DoneW;
   assign stall  = (hit1 | hit2 | waw | cap) & ~FlushD;
   assign accept = IssueD & ~stall & ~FlushD;

   // Set is applied after clear so an issue to the completing register keeps its bit.
   assign pendingNext[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : gPend
         logic setBit, clrBit;
         assign setBit = accept & (RdD == 5'(gi));
         assign clrBit = DoneW & (DoneRd == 5'(gi));
         assign pendingNext[gi] = setBit | (pendingReg[gi] & ~clrBit);
      end
   endgenerate

   always_comb begin
      inFlightNext = inFlightReg;
      if (accept && !DoneW) begin
         inFlightNext = inFlightReg + CW'(1);
      end else if (!accept && DoneW && inFlightReg != '0) begin
         inFlightNext = inFlightReg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pendingReg  <= '0;
         inFlightReg <= '0;
         errReg      <= 1'b0;
      end else begin
         pendingReg  <= pendingNext;
         inFlightReg <= inFlightNext;
         if (DoneW && inFlightReg == '0) begin
            errReg <= 1'b1;
         end
      end
   end

   assign StallF   = stall;
   assign StallD   = stall;
   assign Pending  = pendingReg;
   assign InFlight = inFlightReg;
   assign Full     = isFull;
   assign Err      = errReg;

endmodule
